// File: rtl/vending_machine_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : vending_pkg                                                     |
// | Purpose  : FSM state encoding and default sizing for vending_machine_multi |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int DEF_NUM_PROD   = 4;
  localparam int DEF_CREDIT_W   = 8;
  localparam int STOCK_W        = 8;
  localparam logic [STOCK_W-1:0] STOCK_INIT = 8'd10;

endpackage
`default_nettype wire

// File: rtl/vending_machine_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : vending_machine_multi_if                                       |
// | Purpose   : front-end / dispenser signal bundle; VM_STOCK_COUNT_EN adds    |
// |             restock inputs and sold_out flags                              |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface vending_machine_multi_if #(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter int SEL_W    = $clog2(NUM_PROD)
);
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel_id;
  logic                cancel_request;
  logic                price_wr_en;
  logic [SEL_W-1:0]    price_wr_id;
  logic [CREDIT_W-1:0] price_wr_data;
  logic                product_dispensed;
  logic [SEL_W-1:0]    dispensed_id;
  logic                change_dispensed;
  logic [CREDIT_W-1:0] refund_amount;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
`ifdef VM_STOCK_COUNT_EN
  logic                restock_en;
  logic [SEL_W-1:0]    restock_id;
  logic [7:0]          restock_qty;
  logic [NUM_PROD-1:0] sold_out;
`endif

  modport master (
    output coin_valid, coin_value, sel_valid, sel_id, cancel_request,
           price_wr_en, price_wr_id, price_wr_data,
    input  product_dispensed, dispensed_id, change_dispensed, refund_amount,
           coin_reject, credit, busy
`ifdef VM_STOCK_COUNT_EN
    , output restock_en, restock_id, restock_qty
    , input  sold_out
`endif
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_id, cancel_request,
           price_wr_en, price_wr_id, price_wr_data,
    output product_dispensed, dispensed_id, change_dispensed, refund_amount,
           coin_reject, credit, busy
`ifdef VM_STOCK_COUNT_EN
    , input  restock_en, restock_id, restock_qty
    , output sold_out
`endif
  );

endinterface
`default_nettype wire

// File: rtl/vending_machine_multi_price_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vm_price_table                                                  |
// | Purpose  : NUM_PROD x CREDIT_W price register file, one write, async read  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vm_price_table #(
  parameter int NUM_PROD = 4,
  parameter int SEL_W    = $clog2(NUM_PROD),
  parameter int CREDIT_W = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_INIT = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_id,
  input  logic [CREDIT_W-1:0] wr_data,
  input  logic [SEL_W-1:0]    rd_id,
  output logic [CREDIT_W-1:0] rd_data
);
  localparam logic [SEL_W:0] NUM_PROD_W = (SEL_W+1)'(NUM_PROD);

  logic [CREDIT_W-1:0] prices [NUM_PROD];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROD; i++)
        prices[i] <= PRICE_INIT[i*CREDIT_W +: CREDIT_W];
    end else if (wr_en) begin
      for (int i = 0; i < NUM_PROD; i++)
        if (wr_id == SEL_W'(i))
          prices[i] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_id} < NUM_PROD_W) ? prices[rd_id] : '0;

endmodule
`default_nettype wire

// File: rtl/vending_machine_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vending_machine_multi                                           |
// | Purpose  : N-product vending controller with credit, change and refund.    |
// |            Optional macro VM_STOCK_COUNT_EN adds per-product stock.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int NUM_PROD = DEF_NUM_PROD,
  parameter int SEL_W    = $clog2(NUM_PROD),
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_INIT = {8'd15, 8'd10, 8'd5, 8'd5},
  parameter logic [CREDIT_W-1:0] CREDIT_MAX = 8'd200
) (
  input logic                   clk,
  input logic                   reset,
  vending_machine_multi_if.slave bus
);
  localparam logic [SEL_W:0] NUM_PROD_W = (SEL_W+1)'(NUM_PROD);

  state_t              r_state, w_state_nx;
  logic [CREDIT_W-1:0] r_credit, w_credit_nx;
  logic [CREDIT_W-1:0] r_remainder, w_rem_nx;
  logic [CREDIT_W-1:0] w_total, w_price;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_open, w_coin_ok, w_coin_rej, w_sel_ok, w_cancel;
  logic                w_sel_in_range, w_stock_ok, w_price_we;

  logic                r_pd, w_pd_nx;
  logic [SEL_W-1:0]    r_did, w_did_nx;
  logic                r_cd, w_cd_nx;
  logic [CREDIT_W-1:0] r_refund, w_refund_nx;
  logic                r_rej, w_rej_nx;
  logic                r_busy, w_busy_nx;

  assign w_price_we = bus.price_wr_en && (r_state == IDLE) && (r_credit == '0);

  vm_price_table #(
    .NUM_PROD   (NUM_PROD),
    .SEL_W      (SEL_W),
    .CREDIT_W   (CREDIT_W),
    .PRICE_INIT (PRICE_INIT)
  ) u_price_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_price_we),
    .wr_id   (bus.price_wr_id),
    .wr_data (bus.price_wr_data),
    .rd_id   (bus.sel_id),
    .rd_data (w_price)
  );

  // Credit seen by a select already includes a coin accepted in the same cycle.
  assign w_open         = (r_state == IDLE) || (r_state == COLLECT);
  assign w_coin_sum     = {1'b0, r_credit} + {1'b0, bus.coin_value};
  assign w_coin_ok      = bus.coin_valid && w_open && (w_coin_sum <= {1'b0, CREDIT_MAX});
  assign w_coin_rej     = bus.coin_valid && !w_coin_ok;
  assign w_total        = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : r_credit;
  assign w_sel_in_range = {1'b0, bus.sel_id} < NUM_PROD_W;
  assign w_cancel       = bus.cancel_request && w_open;
  assign w_sel_ok       = bus.sel_valid && w_open && w_sel_in_range && w_stock_ok
                          && (w_total >= w_price);

`ifdef VM_STOCK_COUNT_EN
  logic [STOCK_W-1:0] r_stock     [NUM_PROD];
  logic [STOCK_W-1:0] w_stock_nx  [NUM_PROD];
  logic [STOCK_W:0]   w_stock_sum [NUM_PROD];

  assign w_stock_ok = w_sel_in_range && (r_stock[bus.sel_id] != '0);

  // A vend always has stock >= 1, so the decrement cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      w_stock_sum[i] = {1'b0, r_stock[i]}
                     - (((r_state == VEND) && (r_did == SEL_W'(i))) ? 9'd1 : 9'd0)
                     + ((bus.restock_en && (bus.restock_id == SEL_W'(i)))
                        ? {1'b0, bus.restock_qty} : 9'd0);
      w_stock_nx[i]  = w_stock_sum[i][STOCK_W] ? {STOCK_W{1'b1}} : w_stock_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROD; i++)
      r_stock[i] <= (!reset) ? STOCK_INIT : w_stock_nx[i];
  end

  for (genvar g = 0; g < NUM_PROD; g++) begin : g_sold_out
    assign bus.sold_out[g] = (r_stock[g] == '0);
  end
`else
  assign w_stock_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE, COLLECT: begin
        if (w_cancel)       w_state_nx = (w_total != '0) ? CHANGE : IDLE;
        else if (w_sel_ok)  w_state_nx = VEND;
        else if (w_coin_ok) w_state_nx = COLLECT;
      end
      VEND:    w_state_nx = (r_remainder != '0) ? CHANGE : IDLE;
      CHANGE:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Credit tracks what is still owed: the remainder through VEND and CHANGE.
  always_comb begin
    w_credit_nx = r_credit;
    w_rem_nx    = r_remainder;
    case (r_state)
      IDLE, COLLECT: begin
        if (w_cancel) begin
          w_credit_nx = w_total;
          w_rem_nx    = w_total;
        end else if (w_sel_ok) begin
          w_credit_nx = w_total - w_price;
          w_rem_nx    = w_total - w_price;
        end else begin
          w_credit_nx = w_total;
        end
      end
      CHANGE: begin
        w_credit_nx = '0;
        w_rem_nx    = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_pd_nx     = (w_state_nx == VEND);
    w_did_nx    = w_pd_nx ? bus.sel_id : '0;
    w_cd_nx     = (w_state_nx == CHANGE);
    w_refund_nx = w_cd_nx ? w_rem_nx : '0;
    w_rej_nx    = w_coin_rej;
    w_busy_nx   = w_pd_nx || w_cd_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_credit    <= '0;
      r_remainder <= '0;
      r_pd        <= 1'b0;
      r_did       <= '0;
      r_cd        <= 1'b0;
      r_refund    <= '0;
      r_rej       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_credit    <= w_credit_nx;
      r_remainder <= w_rem_nx;
      r_pd        <= w_pd_nx;
      r_did       <= w_did_nx;
      r_cd        <= w_cd_nx;
      r_refund    <= w_refund_nx;
      r_rej       <= w_rej_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign bus.product_dispensed = r_pd;
  assign bus.dispensed_id      = r_did;
  assign bus.change_dispensed  = r_cd;
  assign bus.refund_amount     = r_refund;
  assign bus.coin_reject       = r_rej;
  assign bus.credit            = r_credit;
  assign bus.busy              = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vending_machine_multi                                        |
// | Purpose  : table-driven self-checking bench with expected-output queue     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vending_machine_multi;

  typedef struct packed {
    logic       pd;
    logic [1:0] did;
    logic       cd;
    logic [7:0] refund;
    logic       rej;
    logic [7:0] credit;
    logic       busy;
  } exp_t;

  typedef struct {
    int   coin;   // -1: no coin
    int   sel;    // -1: no select
    bit   cancel;
    int   pw_id;  // -1: no price write
    int   pw_data;
    exp_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[$];

  vending_machine_multi_if #(.NUM_PROD(4), .CREDIT_W(8)) vif ();

  vending_machine_multi #(.NUM_PROD(4), .CREDIT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int coin, int sel, bit cancel, int pw_id, int pw_data,
                              bit pd, int did, bit cd, int refund, bit rej, int cr, bit busy);
    vec_t v;
    v.coin = coin; v.sel = sel; v.cancel = cancel; v.pw_id = pw_id; v.pw_data = pw_data;
    v.exp.pd = pd; v.exp.did = 2'(did); v.exp.cd = cd; v.exp.refund = 8'(refund);
    v.exp.rej = rej; v.exp.credit = 8'(cr); v.exp.busy = busy;
    return v;
  endfunction

  function automatic vec_t idle_zero();
    return mk(-1, -1, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check_out(input string tag);
    exp_t e, a;
    e = sb.pop_front();
    a = {vif.product_dispensed, vif.dispensed_id, vif.change_dispensed, vif.refund_amount,
         vif.coin_reject, vif.credit, vif.busy};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pd=%0b id=%0d cd=%0b refund=%0d rej=%0b credit=%0d busy=%0b, expected pd=%0b id=%0d cd=%0b refund=%0d rej=%0b credit=%0d busy=%0b",
               tag, a.pd, a.did, a.cd, a.refund, a.rej, a.credit, a.busy,
               e.pd, e.did, e.cd, e.refund, e.rej, e.credit, e.busy);
    end
  endtask

  // Inputs are driven for one cycle; the registered outputs are checked after that edge.
  task automatic apply(input vec_t v, input bit rst_n, input string tag);
    @(negedge clk);
    reset              = rst_n;
    vif.coin_valid     = (v.coin >= 0);
    vif.coin_value     = (v.coin >= 0) ? 8'(v.coin) : 8'd0;
    vif.sel_valid      = (v.sel >= 0);
    vif.sel_id         = (v.sel >= 0) ? 2'(v.sel) : 2'd0;
    vif.cancel_request = v.cancel;
    vif.price_wr_en    = (v.pw_id >= 0);
    vif.price_wr_id    = (v.pw_id >= 0) ? 2'(v.pw_id) : 2'd0;
    vif.price_wr_data  = 8'(v.pw_data);
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic check_bit(input string tag, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", tag, act, req);
    end
  endtask

  initial begin
    vif.coin_valid = 0; vif.coin_value = 0; vif.sel_valid = 0; vif.sel_id = 0;
    vif.cancel_request = 0; vif.price_wr_en = 0; vif.price_wr_id = 0; vif.price_wr_data = 0;
`ifdef VM_STOCK_COUNT_EN
    vif.restock_en = 0; vif.restock_id = 0; vif.restock_qty = 0;
`endif

    // Entry 0 defaults to 5; entries 1 and 2 are programmed to 10 and 15 first.
    //            coin sel can pw_id pw_d  pd id cd ref rej cr busy
    tbl.push_back(mk(-1, -1, 0,  1, 10,   0, 0, 0,   0, 0,   0, 0));
    tbl.push_back(mk(-1, -1, 0,  2, 15,   0, 0, 0,   0, 0,   0, 0));
    tbl.push_back(mk( 5, -1, 0, -1,  0,   0, 0, 0,   0, 0,   5, 0));
    tbl.push_back(mk( 5, -1, 0, -1,  0,   0, 0, 0,   0, 0,  10, 0));
    tbl.push_back(mk(-1,  1, 0, -1,  0,   1, 1, 0,   0, 0,   0, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(20, -1, 0, -1,  0,   0, 0, 0,   0, 0,  20, 0));
    tbl.push_back(mk(-1,  2, 0, -1,  0,   1, 2, 0,   0, 0,   5, 1));
    tbl.push_back(mk(-1, -1, 0, -1,  0,   0, 0, 1,   5, 0,   5, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(100,-1, 0, -1,  0,   0, 0, 0,   0, 0, 100, 0));
    tbl.push_back(mk(100,-1, 0, -1,  0,   0, 0, 0,   0, 0, 200, 0));
    tbl.push_back(mk( 5, -1, 0, -1,  0,   0, 0, 0,   0, 1, 200, 0));
    tbl.push_back(mk(-1, -1, 1, -1,  0,   0, 0, 1, 200, 0, 200, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk( 5,  0, 1, -1,  0,   0, 0, 1,   5, 0,   5, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk( 3, -1, 0, -1,  0,   0, 0, 0,   0, 0,   3, 0));
    tbl.push_back(mk(-1, -1, 0,  0,  7,   0, 0, 0,   0, 0,   3, 0));
    tbl.push_back(mk( 4,  0, 0, -1,  0,   1, 0, 0,   0, 0,   2, 1));
    tbl.push_back(mk( 5, -1, 0, -1,  0,   0, 0, 1,   2, 1,   2, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(-1, -1, 0,  0,  7,   0, 0, 0,   0, 0,   0, 0));
    tbl.push_back(mk( 5, -1, 0, -1,  0,   0, 0, 0,   0, 0,   5, 0));
    tbl.push_back(mk(-1,  0, 0, -1,  0,   0, 0, 0,   0, 0,   5, 0));
    tbl.push_back(mk( 2,  0, 0, -1,  0,   1, 0, 0,   0, 0,   0, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(-1, -1, 1, -1,  0,   0, 0, 0,   0, 0,   0, 0));
    tbl.push_back(mk(-1, -1, 0,  3,  0,   0, 0, 0,   0, 0,   0, 0));
    tbl.push_back(mk(-1,  3, 0, -1,  0,   1, 3, 0,   0, 0,   0, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(150,-1, 0, -1,  0,   0, 0, 0,   0, 0, 150, 0));
    tbl.push_back(mk(50, -1, 0, -1,  0,   0, 0, 0,   0, 0, 200, 0));
    tbl.push_back(mk( 1, -1, 0, -1,  0,   0, 0, 0,   0, 1, 200, 0));
    tbl.push_back(mk( 1,  2, 0, -1,  0,   1, 2, 0,   0, 1, 185, 1));
    tbl.push_back(mk(-1, -1, 0, -1,  0,   0, 0, 1, 185, 0, 185, 1));
    tbl.push_back(idle_zero());
    tbl.push_back(mk(10,  1, 0, -1,  0,   1, 1, 0,   0, 0,   0, 1));
    tbl.push_back(idle_zero());

    apply(idle_zero(), 1'b0, "reset0");
    apply(idle_zero(), 1'b0, "reset1");

    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset while in VEND: the pending change is lost and prices revert.
    apply(mk(20, 0, 0, -1, 0, 1, 0, 0, 0, 0, 13, 1), 1'b1, "rst_seq_vend");
    apply(idle_zero(), 1'b0, "rst_seq_reset");
    apply(mk(5, 0, 0, -1, 0, 1, 0, 0, 0, 0, 0, 1), 1'b1, "rst_seq_price_restored");
    apply(idle_zero(), 1'b1, "rst_seq_idle");

`ifdef VM_STOCK_COUNT_EN
    apply(mk(-1, -1, 0, 3, 15, 0, 0, 0, 0, 0, 0, 0), 1'b1, "stk_price3");
    check_bit("stk_initial_sold_out3", vif.sold_out[3], 1'b0);
    for (int k = 0; k < 10; k++) begin
      apply(mk(15, 3, 0, -1, 0, 1, 3, 0, 0, 0, 0, 1), 1'b1, $sformatf("stk_vend%0d", k));
      apply(idle_zero(), 1'b1, $sformatf("stk_idle%0d", k));
    end
    check_bit("stk_sold_out3", vif.sold_out[3], 1'b1);
    apply(mk(15, 3, 0, -1, 0, 0, 0, 0, 0, 0, 15, 0), 1'b1, "stk_select_ignored");
    apply(mk(-1, -1, 1, -1, 0, 0, 0, 1, 15, 0, 15, 1), 1'b1, "stk_cancel");
    apply(idle_zero(), 1'b1, "stk_idle_after_cancel");
    @(negedge clk);
    vif.restock_en = 1; vif.restock_id = 2'd3; vif.restock_qty = 8'd2;
    @(posedge clk);
    #1;
    vif.restock_en = 0;
    check_bit("stk_restocked", vif.sold_out[3], 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
